// File: rtl/sound_pkg.sv
// Shared types, constants and helpers for the sound mixer and its sigma-delta DAC.
package sound_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MIX   = 2'd1,
        SCALE = 2'd2,
        LOAD  = 2'd3
    } mix_state_e;

    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sound_sdm.sv
// First-order sigma-delta modulator with its own update-rate divider.
// Build option SOUND_MIXER_DITHER_EN adds an LFSR carry-in advanced on every modulator update.
module sound_sdm
    import sound_pkg::*;
#(
    parameter int DAC_W   = 8,
    parameter int MOD_DIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DAC_W-1:0] level,
    output logic             o_pwm
);

    localparam int               CNT_W    = (MOD_DIV > 1) ? clog2(MOD_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MOD_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mod_tick;
    logic [DAC_W:0]   acc_q, acc_d;
    logic             cin;

    assign mod_tick = (cnt_q == CNT_LAST);
    assign cnt_d    = mod_tick ? '0 : cnt_q + 1'b1;
    assign acc_d    = {1'b0, acc_q[DAC_W-1:0]} + {1'b0, level} + {{DAC_W{1'b0}}, cin};

`ifdef SOUND_MIXER_DITHER_EN
    logic [15:0] lfsr_q, lfsr_d;

    assign cin    = lfsr_q[0];
    assign lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else if (mod_tick) begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign cin = 1'b0;
`endif

    // Level is sampled only on mod_tick, so a new level never lands mid-update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (mod_tick) begin
                acc_q <= acc_d;
            end
        end
    end

    assign o_pwm = acc_q[DAC_W];

endmodule

// File: rtl/sound_mixer_dac.sv
// Per-frame multi-channel volume mixer (one MAC per clock) feeding a 1-bit sigma-delta DAC.
// Build option SOUND_MIXER_DITHER_EN enables LFSR dither inside sound_sdm.
//
// state | meaning
// IDLE  | waiting for frame_tick; inputs snapshotted on the tick
// MIX   | accumulate one channel product per clock
// SCALE | gain shift, truncate to DAC_W, saturate
// LOAD  | move saturated value to dac_level
module sound_mixer_dac
    import sound_pkg::*;
#(
    parameter int CHANNELS   = 4,
    parameter int SAMPLE_W   = 8,
    parameter int VOL_W      = 4,
    parameter int DAC_W      = 8,
    parameter int GAIN_SHIFT = 0,
    parameter int FRAME_DIV  = 256,
    parameter int MOD_DIV    = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CHANNELS*SAMPLE_W-1:0] ch_sample,
    input  logic [CHANNELS*VOL_W-1:0]    ch_volume,
    input  logic [CHANNELS-1:0]          ch_mute,
    output logic                         mix_busy,
    output logic                         mix_valid,
    output logic [DAC_W-1:0]             dac_level,
    output logic                         o_pwm
);

    localparam int PROD_W = SAMPLE_W + VOL_W;
    localparam int SUM_W  = PROD_W + clog2(CHANNELS);
    localparam int EXT_W  = SUM_W + 3;
    localparam int SHR    = SUM_W - DAC_W;
    localparam int IDX_W  = (CHANNELS > 1) ? clog2(CHANNELS) : 1;
    localparam int FR_W   = (FRAME_DIV > 1) ? clog2(FRAME_DIV) : 1;

    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(CHANNELS - 1);
    localparam logic [FR_W-1:0]  FRAME_LAST = FR_W'(FRAME_DIV - 1);

    mix_state_e state_q, state_d;

    logic [FR_W-1:0]              frame_cnt_q, frame_cnt_d;
    logic                         frame_tick;
    logic [CHANNELS*SAMPLE_W-1:0] snap_sample_q;
    logic [CHANNELS*VOL_W-1:0]    snap_volume_q;
    logic [CHANNELS-1:0]          snap_mute_q;
    logic [IDX_W-1:0]             idx_q;
    logic [SUM_W-1:0]             sum_q;
    logic [DAC_W-1:0]             sat_q, sat_d;
    logic [DAC_W-1:0]             dac_level_q;
    logic                         mix_valid_q;
    logic                         snap_en, acc_en, scale_en, load_en;
    logic [SAMPLE_W-1:0]          cur_sample;
    logic [VOL_W-1:0]             cur_volume;
    logic [PROD_W-1:0]            product;
    logic [EXT_W-1:0]             shifted;

    assign frame_tick  = (frame_cnt_q == FRAME_LAST);
    assign frame_cnt_d = frame_tick ? '0 : frame_cnt_q + 1'b1;

    assign cur_sample = snap_sample_q[idx_q*SAMPLE_W +: SAMPLE_W];
    assign cur_volume = snap_volume_q[idx_q*VOL_W +: VOL_W];
    assign product    = snap_mute_q[idx_q] ? '0 : PROD_W'(cur_sample) * PROD_W'(cur_volume);

    // Anything left above DAC_W after the shift can only come from the gain
    assign shifted = (EXT_W'(sum_q) << GAIN_SHIFT) >> SHR;
    assign sat_d   = (|shifted[EXT_W-1:DAC_W]) ? '1 : shifted[DAC_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (frame_tick) state_d = MIX;
            MIX:     if (idx_q == IDX_LAST) state_d = SCALE;
            SCALE:   state_d = LOAD;
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mix_busy = 1'b0;
        snap_en  = 1'b0;
        acc_en   = 1'b0;
        scale_en = 1'b0;
        load_en  = 1'b0;
        case (state_q)
            IDLE:    snap_en = frame_tick;
            MIX:     begin mix_busy = 1'b1; acc_en   = 1'b1; end
            SCALE:   begin mix_busy = 1'b1; scale_en = 1'b1; end
            LOAD:    begin mix_busy = 1'b1; load_en  = 1'b1; end
            default: mix_busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q   <= '0;
            snap_sample_q <= '0;
            snap_volume_q <= '0;
            snap_mute_q   <= '0;
            idx_q         <= '0;
            sum_q         <= '0;
            sat_q         <= '0;
            dac_level_q   <= '0;
            mix_valid_q   <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            mix_valid_q <= load_en;
            if (snap_en) begin
                snap_sample_q <= ch_sample;
                snap_volume_q <= ch_volume;
                snap_mute_q   <= ch_mute;
                idx_q         <= '0;
                sum_q         <= '0;
            end
            if (acc_en) begin
                sum_q <= sum_q + SUM_W'(product);
                idx_q <= idx_q + 1'b1;
            end
            if (scale_en) begin
                sat_q <= sat_d;
            end
            if (load_en) begin
                dac_level_q <= sat_q;
            end
        end
    end

    assign mix_valid = mix_valid_q;
    assign dac_level = dac_level_q;

    frame_tick_while_busy: assert property (@(posedge clk) disable iff (!rst_n) !(frame_tick && mix_busy));

    sound_sdm #(
        .DAC_W   (DAC_W),
        .MOD_DIV (MOD_DIV)
    ) u_sdm (
        .clk   (clk),
        .rst_n (rst_n),
        .level (dac_level_q),
        .o_pwm (o_pwm)
    );

endmodule

// File: tb/tb_sound_mixer_dac.sv
// Directed bench for sound_mixer_dac: mix levels, latency, snapshot, reset, modulator duty.
module tb_sound_mixer_dac;

    localparam int CH = 4;
    localparam int SW = 8;
    localparam int VW = 4;
    localparam int DW = 8;
    localparam int FD = 256;
    localparam int MD = 2;
    localparam int LATENCY = FD - 1 + CH + 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CH*SW-1:0] ch_sample;
    logic [CH*VW-1:0] ch_volume;
    logic [CH-1:0]    ch_mute;
    logic             mix_busy, mix_valid, o_pwm;
    logic [DW-1:0]    dac_level;
    logic             g1_busy, g1_valid, g1_pwm;
    logic [DW-1:0]    g1_level;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sound_mixer_dac #(
        .CHANNELS(CH), .SAMPLE_W(SW), .VOL_W(VW), .DAC_W(DW),
        .GAIN_SHIFT(0), .FRAME_DIV(FD), .MOD_DIV(MD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ch_sample(ch_sample), .ch_volume(ch_volume),
        .ch_mute(ch_mute), .mix_busy(mix_busy), .mix_valid(mix_valid),
        .dac_level(dac_level), .o_pwm(o_pwm)
    );

    sound_mixer_dac #(
        .CHANNELS(CH), .SAMPLE_W(SW), .VOL_W(VW), .DAC_W(DW),
        .GAIN_SHIFT(1), .FRAME_DIV(FD), .MOD_DIV(MD)
    ) dut_g1 (
        .clk(clk), .rst_n(rst_n), .ch_sample(ch_sample), .ch_volume(ch_volume),
        .ch_mute(ch_mute), .mix_busy(g1_busy), .mix_valid(g1_valid),
        .dac_level(g1_level), .o_pwm(g1_pwm)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_inputs(input logic [SW-1:0] s0, input logic [SW-1:0] s1,
                              input logic [SW-1:0] s2, input logic [SW-1:0] s3,
                              input logic [VW-1:0] vol, input logic [CH-1:0] mute);
        ch_sample = {s3, s2, s1, s0};
        ch_volume = {CH{vol}};
        ch_mute   = mute;
    endtask

    task automatic sync_idle(input string tag);
        int n;
        n = 0;
        while (mix_busy && n < 20) begin
            step(1);
            n++;
        end
        if (mix_busy) check({tag, " idle timeout"}, 0, 1);
    endtask

    task automatic wait_busy(input string tag);
        int n;
        n = 0;
        while (!mix_busy && n < 300) begin
            step(1);
            n++;
        end
        if (!mix_busy) check({tag, " busy timeout"}, 0, 1);
    endtask

    task automatic wait_valid(input string tag, output int clocks);
        clocks = 0;
        while (!mix_valid && clocks < 600) begin
            step(1);
            clocks++;
        end
        if (!mix_valid) check({tag, " valid timeout"}, 0, 1);
    endtask

    task automatic count_pwm(input int ticks, output int ones, output int ones_g1);
        ones    = 0;
        ones_g1 = 0;
        for (int i = 0; i < ticks; i++) begin
            ones    += int'(o_pwm);
            ones_g1 += int'(g1_pwm);
            step(MD);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int clocks, ones, ones_g1, k;
        set_inputs(8'd0, 8'd0, 8'd0, 8'd0, 4'd15, 4'b0000);
        rst_n = 1'b0;
        step(3);
        check("rst busy", int'(mix_busy), 0);
        check("rst valid", int'(mix_valid), 0);
        check("rst level", int'(dac_level), 0);
        check("rst pwm", int'(o_pwm), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: silence, plus first-frame latency from reset release
        wait_valid("t1", clocks);
        check("t1 latency", clocks, LATENCY);
        check("t1 level", int'(dac_level), 0);
        step(1);
        check("t1 valid one clock", int'(mix_valid), 0);
`ifndef SOUND_MIXER_DITHER_EN
        count_pwm(1024, ones, ones_g1);
        check("t1 pwm ones", ones, 0);
`endif

        // Test 2: single channel 255*15 = 3825 -> 59 (g1: 7650 -> 119)
        sync_idle("t2");
        set_inputs(8'd255, 8'd0, 8'd0, 8'd0, 4'd15, 4'b0000);
        wait_busy("t2");
        wait_valid("t2", clocks);
        check("t2 level", int'(dac_level), 59);
        check("t2 g1 level", int'(g1_level), 119);
`ifndef SOUND_MIXER_DITHER_EN
        // Load edge coincides with a mod tick; old level 0 there means first carry after 5 more ticks
        k = 0;
        while (!o_pwm && k < 40) begin
            step(1);
            k++;
        end
        check("t2 first one delay", k, 10);
        step(4);
        count_pwm(256, ones, ones_g1);
        check("t2 ones per 256", ones, 59);
`endif

        // Test 3: all channels full -> 239; g1 saturates 478 -> 255
        sync_idle("t3");
        set_inputs(8'd255, 8'd255, 8'd255, 8'd255, 4'd15, 4'b0000);
        wait_busy("t3");
        wait_valid("t3", clocks);
        check("t3 level", int'(dac_level), 239);
        check("t3 g1 saturated", int'(g1_level), 255);
`ifndef SOUND_MIXER_DITHER_EN
        step(4);
        count_pwm(256, ones, ones_g1);
        check("t3 ones per 256", ones, 239);
        check("t3 g1 ones per 256", ones_g1, 255);
`endif

        // Test 4: mute 0101 -> 7650 -> 119 (g1 239); inputs scrambled during MIX
        sync_idle("t4");
        set_inputs(8'd255, 8'd255, 8'd255, 8'd255, 4'd15, 4'b0101);
        wait_busy("t4");
        set_inputs(8'd0, 8'd0, 8'd0, 8'd0, 4'd0, 4'b1111);
        wait_valid("t4", clocks);
        check("t4 level", int'(dac_level), 119);
        check("t4 g1 level", int'(g1_level), 239);

        // Test 5: reset pulse mid-MIX, then a clean frame
        sync_idle("t5");
        set_inputs(8'd255, 8'd0, 8'd0, 8'd0, 4'd15, 4'b0000);
        wait_busy("t5");
        step(2);
        check("t5 busy before reset", int'(mix_busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t5 busy async drop", int'(mix_busy), 0);
        check("t5 level cleared", int'(dac_level), 0);
        check("t5 pwm cleared", int'(o_pwm), 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_valid("t5", clocks);
        check("t5 latency", clocks, LATENCY);
        check("t5 level", int'(dac_level), 59);
        check("t5 g1 level", int'(g1_level), 119);

`ifdef SOUND_MIXER_DITHER_EN
        // Test 6: 255*15+255*15+40*15 = 8250 -> 128, dithered duty
        begin
            logic p1, p2, brk;
            int breaks;
            sync_idle("t6");
            set_inputs(8'd255, 8'd255, 8'd40, 8'd0, 4'd15, 4'b0000);
            wait_busy("t6");
            wait_valid("t6", clocks);
            check("t6 level", int'(dac_level), 128);
            step(4);
            ones   = 0;
            breaks = 0;
            p1     = 1'b0;
            p2     = 1'b0;
            for (int w = 0; w < 512; w++) begin
                brk = 1'b0;
                for (int j = 0; j < 64; j++) begin
                    if (j >= 2 && o_pwm != p2) brk = 1'b1;
                    ones += int'(o_pwm);
                    p2 = p1;
                    p1 = o_pwm;
                    step(MD);
                end
                breaks += int'(brk);
            end
            check("t6 ones in range", int'(ones >= 16384 && ones <= 16512), 1);
            check("t6 period-2 broken", int'(breaks > 0), 1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sound_mixer_dac.md
Name: sound_mixer_dac

Overview:
- Parametrised successor to the single-bit PWM sound output.
- Mixes CHANNELS unsigned samples, each with its own volume and mute, into one DAC_W-bit level once per frame, using one multiply-accumulate per clock.
- Drives a first-order sigma-delta 1-bit output at a programmable modulator rate.
- Sits between the sound sources (beeper, timer channels, tape) and the board audio pin.

Parameters:
- CHANNELS, 4, number of input channels (1..16).
- SAMPLE_W, 8, width of each unsigned channel sample.
- VOL_W, 4, width of each channel volume; 0 = silent, 2^VOL_W-1 = full scale.
- DAC_W, 8, modulator input width.
- GAIN_SHIFT, 0, extra left shift of the mix before saturation (0..3).
- FRAME_DIV, 256, clocks per mix frame; must be at least CHANNELS+3.
- MOD_DIV, 2, clocks per modulator update (1..256). The default of 2 matches the legacy rate.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ch_sample  in  CHANNELS*SAMPLE_W  packed samples; channel i occupies bits [i*SAMPLE_W +: SAMPLE_W]
- ch_volume  in  CHANNELS*VOL_W  packed volumes, same packing
- ch_mute  in  CHANNELS  per-channel mute, 1 = excluded from the mix
- mix_busy  out  1  high while the mixer FSM is outside IDLE
- mix_valid  out  1  one-clock pulse when dac_level updates
- dac_level  out  DAC_W  current modulator input (for debug and the test bench)
- o_pwm  out  1  1-bit sigma-delta audio output

Behaviour:
- Reset (asynchronous, active-low, clk is the only clock):
  - All outputs 0; all counters, FSM state, accumulators and snapshots 0.
  - On deassertion the frame and modulator counters start from 0.
- Frame timer:
  - Counts 0..FRAME_DIV-1 and wraps.
  - frame_tick is asserted while the count equals FRAME_DIV-1.
- Mixer FSM states: IDLE, MIX, SCALE, LOAD.
  - IDLE: on frame_tick, snapshot ch_sample, ch_volume and ch_mute into internal registers, clear sum and idx, then go to MIX. Later input changes do not affect this frame.
  - MIX: one channel per clock. sum += (snap_mute[idx] ? 0 : snap_sample[idx]*snap_volume[idx]). After idx = CHANNELS-1, go to SCALE.
  - SCALE: shifted = (sum << GAIN_SHIFT) >> (SUM_W-DAC_W); saturate to 2^DAC_W-1. Go to LOAD.
  - LOAD: dac_level <= saturated value and mix_valid = 1 for this clock. Go to IDLE.
- Mix latency: CHANNELS+3 clocks from frame_tick to the dac_level update.
- mix_busy is high in MIX, SCALE and LOAD.
- A frame_tick cannot occur while busy because of the FRAME_DIV constraint. An assertion flags any violation.
- Width rules:
  - Each product is SAMPLE_W+VOL_W bits.
  - SUM_W = SAMPLE_W+VOL_W+clog2(CHANNELS), with a minimum of SAMPLE_W+VOL_W when CHANNELS=1. The sum never overflows.
  - The shift is logical. Saturation applies only when GAIN_SHIFT>0.
- Modulator:
  - mod_tick fires every MOD_DIV clocks, from its own counter.
  - On mod_tick: acc <= acc[DAC_W-1:0] + dac_level + cin, where acc is DAC_W+1 bits.
  - o_pwm = acc[DAC_W], registered.
  - A dac_level change takes effect at the next mod_tick; there is no glitch mid-tick.
  - Duty = dac_level/2^DAC_W over each run of 2^DAC_W mod_ticks.
- Boundary cases:
  - dac_level 0: o_pwm stays 0.
  - dac_level 2^DAC_W-1: exactly one 0 in every 2^DAC_W mod_ticks.
  - mix_valid coinciding with mod_tick: the modulator uses the old level for that tick.
- Reset mid-operation: the FSM is forced to IDLE, mix_busy drops immediately (asynchronously), and the partial sum is discarded.

Optional Feature:
- Macro: SOUND_MIXER_DITHER_EN.
- When defined:
  - A 16-bit Galois LFSR (polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset) advances on each mod_tick.
  - cin = lfsr[0], which breaks up idle tones.
  - The long-run mean duty is unchanged to within 1 LSB.
- When undefined: cin = 0, no LFSR logic, and output is bit-exact with the plain first-order modulator.

Decomposition:
- Package sound_pkg holds:
  - clog2 function;
  - mixer FSM state enum (IDLE/MIX/SCALE/LOAD);
  - LFSR seed and tap constants.
- SUM_W is derived locally as a localparam from sound_pkg::clog2.
- One natural sub-module: sound_sdm, containing the modulator counter, accumulator, optional LFSR and o_pwm register. Its parameters are DAC_W and MOD_DIV; its inputs are clk, rst_n and level.

Test Plan (defaults: CHANNELS=4, SAMPLE_W=8, VOL_W=4, DAC_W=8, SUM_W=14, shift 6):
1. All samples 0, volumes 15 -> dac_level 0; o_pwm 0 for 1024 mod_ticks.
2. ch0 = 255, vol 15, others 0 -> sum 3825, dac_level 59; exactly 59 ones per 256 mod_ticks; mix_valid exactly CHANNELS+3 = 7 clocks after frame_tick.
3. All channels 255, vol 15 -> sum 15300, dac_level 239. With GAIN_SHIFT=1 -> 478 saturates to 255; 255 ones per 256 mod_ticks.
4. Same as 3 with ch_mute = 4'b0101 -> sum 7650, dac_level 119. Inputs toggled during MIX do not change the result (snapshot check).
5. rst_n pulsed low for 1 clock mid-MIX -> mix_busy, dac_level and o_pwm read 0 immediately; the next frame completes normally with the correct level.
6. With SOUND_MIXER_DITHER_EN, dac_level 128 -> 32768 mod_ticks; the ones count lies between 16384 and 16384+128 (128/256 duty plus at most 1/256 LFSR carry-in); no period-2 pattern over 64-tick windows.
